// File: rtl/arb2_rr.sv
// Two-requester round-robin arbiter with registered, mutually exclusive grants.
// Optional per-holder grant timeout is built when ARB2_TIMEOUT_EN is defined.
module arb2_rr #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ptr;        // 0: req0 wins the next tie, 1: req1 wins
    logic   ptr_nxt;
    logic   timeout_hit;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("arb2_rr: TIMEOUT must be in 2..255");
    end

`ifdef ARB2_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;

    assign timeout_hit = (hold_cnt == CNT_W'(TIMEOUT - 1));

    // Cycles spent by the current holder; clears on any grant change, saturates at the limit.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (state_nxt != state) begin
            hold_cnt_nxt = '0;
        end else if (state != IDLE && !timeout_hit) begin
            hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and tie pointer update.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || !ptr)) begin
                    state_nxt = G0;
                end else if (req1) begin
                    state_nxt = G1;
                end
            end
            G0: begin
                if (!req0) begin
                    state_nxt = req1 ? G1 : IDLE;
                end else if (timeout_hit && req1) begin
                    state_nxt = G1;
                end
            end
            G1: begin
                if (!req1) begin
                    state_nxt = req0 ? G0 : IDLE;
                end else if (timeout_hit && req0) begin
                    state_nxt = G0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A fresh grant hands the next tie to the other requester.
        if (state_nxt == G0 && state != G0) begin
            ptr_nxt = 1'b1;
        end else if (state_nxt == G1 && state != G1) begin
            ptr_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    assign gnt0 = (state == G0);
    assign gnt1 = (state == G1);
    assign busy = gnt0 | gnt1;

endmodule

// File: tb/tb_arb2_rr.sv
// Self-checking bench for arb2_rr: directed scenarios plus randomized traffic
// checked against a holder/favourite/hold-length reference model.
module tb_arb2_rr;

    localparam int unsigned TO = 4;

    logic clk;
    logic rst;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic busy;

    int n_cmp;
    int n_err;
    bit chk_en;

    // Reference model: who holds the resource, who wins the next tie, how long held so far.
    int m_holder;
    int m_fav;
    int m_held;

    arb2_rr #(.TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ARB2_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    function automatic logic [2:0] model_bits();
        logic g0;
        logic g1;
        g0 = (m_holder == 0);
        g1 = (m_holder == 1);
        return {g0, g1, g0 | g1};
    endfunction

    task automatic model_grant(input int who);
        m_holder = who;
        m_fav    = 1 - who;
        m_held   = 1;
    endtask

    // Apply inputs, clock one edge, advance the model, settle at the falling edge.
    task automatic step(input logic r, input logic a, input logic b);
        bit mine;
        bit other;
        rst  = r;
        req0 = a;
        req1 = b;
        @(posedge clk);
        if (r) begin
            m_holder = -1;
            m_fav    = 0;
            m_held   = 0;
        end else if (m_holder < 0) begin
            if (a && b)  model_grant(m_fav);
            else if (a)  model_grant(0);
            else if (b)  model_grant(1);
        end else begin
            mine  = (m_holder == 0) ? a : b;
            other = (m_holder == 0) ? b : a;
            if (!mine) begin
                if (other) model_grant(1 - m_holder);
                else       m_holder = -1;
            end else if (TO_ON && m_held >= int'(TO) && other) begin
                model_grant(1 - m_holder);
            end else begin
                m_held++;
            end
        end
        @(negedge clk);
    endtask

    // Exclusivity and busy relation on every cycle once out of reset.
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ((gnt0 && gnt1) || (busy !== (gnt0 | gnt1))) begin
                n_err++;
                $display("FAIL invariant t=%0t: gnt0=%b gnt1=%b busy=%b, need exclusive grants and busy=gnt0|gnt1",
                         $time, gnt0, gnt1, busy);
            end
        end
    end

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk_en = 1'b1;
        n_cmp++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset: got %b want 000", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_single();
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b1, 1'b0);
            n_cmp++;
            if ({gnt0, gnt1, busy} !== 3'b101) begin
                n_err++;
                $display("FAIL single_hold c%0d: got %b want 101", c + 1, {gnt0, gnt1, busy});
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL single_release: got %b want 000", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_tie();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({gnt0, gnt1, busy} !== 3'b101) begin
            n_err++;
            $display("FAIL tie_first: got %b want 101", {gnt0, gnt1, busy});
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL tie_idle: got %b want 000", {gnt0, gnt1, busy});
        end
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({gnt0, gnt1, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL tie_second: got %b want 011", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_handoff();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({gnt0, gnt1, busy} !== 3'b101) begin
            n_err++;
            $display("FAIL handoff_hold: got %b want 101", {gnt0, gnt1, busy});
        end
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({gnt0, gnt1, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL handoff_switch: got %b want 011", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid: got %b want 000", {gnt0, gnt1, busy});
        end
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({gnt0, gnt1, busy} !== 3'b101) begin
            n_err++;
            $display("FAIL reset_resume: got %b want 101", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_timeout();
        logic [2:0] want;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1);
            want = (TO_ON && i == 3) ? 3'b011 : 3'b101;
            n_cmp++;
            if ({gnt0, gnt1, busy} !== want) begin
                n_err++;
                $display("FAIL timeout_switch i%0d: got %b want %b", i, {gnt0, gnt1, busy}, want);
            end
        end
        // Alone past the limit: keep the grant, then yield at once when req1 appears.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            n_cmp++;
            if ({gnt0, gnt1, busy} !== 3'b101) begin
                n_err++;
                $display("FAIL timeout_keep i%0d: got %b want 101", i, {gnt0, gnt1, busy});
            end
        end
        step(1'b0, 1'b1, 1'b1);
        want = TO_ON ? 3'b011 : 3'b101;
        n_cmp++;
        if ({gnt0, gnt1, busy} !== want) begin
            n_err++;
            $display("FAIL timeout_saturated: got %b want %b", {gnt0, gnt1, busy}, want);
        end
    endtask

    task automatic test_random();
        logic a;
        logic b;
        logic r;
        a = 1'b0;
        b = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3, 0) == 0) a = ~a;
            if ($urandom_range(3, 0) == 0) b = ~b;
            r = ($urandom_range(49, 0) == 0);
            step(r, a, b);
            n_cmp++;
            if ({gnt0, gnt1, busy} !== model_bits()) begin
                n_err++;
                $display("FAIL random c%0d (rst=%b req=%b%b): got %b want %b",
                         c, r, a, b, {gnt0, gnt1, busy}, model_bits());
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        chk_en   = 1'b0;
        m_holder = -1;
        m_fav    = 0;
        m_held   = 0;
        rst      = 1'b1;
        req0     = 1'b0;
        req1     = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_handoff();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
